// File: rtl/spi_burst_ctrl.sv
// Burst sequencer for spi_master: TX/RX byte FIFOs and a per-byte start/finish handshake.
// Optional watchdog on the handshake wait states is enabled by defining SPI_BURST_TIMEOUT_EN.
module spi_burst_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_cfg_mode,
  input  logic [1:0] i_cfg_clkdiv,
  input  logic       i_go,
  input  logic [7:0] i_burst_len,
  output logic       o_busy,
  output logic       o_done,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_rx_ready,
  output logic       o_spi_start,
  output logic [7:0] o_spi_data,
  output logic [1:0] o_spi_mode,
  output logic [1:0] o_spi_clkdiv,
  input  logic       i_spi_finish,
  input  logic [7:0] i_spi_rdata,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_STORE, S_DONE
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_len;
  logic [7:0]  r_spi_data;
  logic [1:0]  r_mode, r_clkdiv;

  logic [7:0]  r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr, r_tx_rd;
  logic [AW:0] r_tx_cnt;
  logic [7:0]  r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wr, r_rx_rd;
  logic [AW:0] r_rx_cnt;

  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_go_ok, w_timeout;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_push  = i_tx_valid && !w_tx_full;
  assign w_rx_pop   = i_rx_ready && !w_rx_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    w_go_ok     = 1'b0;
    case (r_state)
      S_IDLE: if (i_go && i_burst_len != 8'd0) begin
        w_go_ok     = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: if (!w_tx_empty) begin
        w_tx_pop    = 1'b1;
        w_state_nxt = S_START;
      end
      S_START: w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!i_spi_finish) w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_WAIT_DONE: begin
        if (i_spi_finish) w_state_nxt = S_STORE;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_STORE: if (!w_rx_full) begin
        w_rx_push   = 1'b1;
        w_state_nxt = (r_len == 8'd1) ? S_DONE : S_LOAD;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= 8'd0;
      r_spi_data <= 8'd0;
      r_mode     <= 2'd0;
      r_clkdiv   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go_ok) begin
        r_len    <= i_burst_len;
        r_mode   <= i_cfg_mode;
        r_clkdiv <= i_cfg_clkdiv;
      end else if (w_rx_push) begin
        r_len <= r_len - 8'd1;
      end
      if (w_tx_pop) r_spi_data <= r_tx_mem[r_tx_rd];
    end
  end

  // Storage is not reset; flushing the pointers and counts empties both FIFOs.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= i_tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= i_spi_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

`ifdef SPI_BURST_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_err;
  logic        w_in_wait;

  assign w_in_wait = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE);
  // Timeout only fires when the handshake is not progressing this cycle.
  assign w_timeout = (r_wdog == 16'hFFFF) &&
                     (((r_state == S_WAIT_ACK) && i_spi_finish) ||
                      ((r_state == S_WAIT_DONE) && !i_spi_finish));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 16'd0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_START || (r_state == S_WAIT_ACK && !i_spi_finish))
        r_wdog <= 16'd0;
      else if (w_in_wait)
        r_wdog <= r_wdog + 16'd1;
      if (w_go_ok) r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_spi_start  = (r_state == S_START);
  assign o_spi_data   = r_spi_data;
  assign o_spi_mode   = r_mode;
  assign o_spi_clkdiv = r_clkdiv;
  assign o_tx_ready   = !w_tx_full;
  assign o_rx_valid   = !w_rx_empty;
  assign o_rx_data    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a loopback spi_master model and RX scoreboard.
module tb_spi_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_mode, cfg_clkdiv;
  logic       go;
  logic [7:0] burst_len;
  logic       busy, done;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       spi_start;
  logic [7:0] spi_data;
  logic [1:0] spi_mode, spi_clkdiv;
  logic       spi_finish;
  logic [7:0] spi_rdata;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;
  int n_start = 0;
  int n_done  = 0;
  bit m_stall = 1'b0;
  logic [7:0] exp_q[$];

  spi_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_mode(cfg_mode), .i_cfg_clkdiv(cfg_clkdiv),
    .i_go(go), .i_burst_len(burst_len),
    .o_busy(busy), .o_done(done),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
    .o_spi_start(spi_start), .o_spi_data(spi_data),
    .o_spi_mode(spi_mode), .o_spi_clkdiv(spi_clkdiv),
    .i_spi_finish(spi_finish), .i_spi_rdata(spi_rdata),
    .o_err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // spi_master model: acknowledges a start, then returns the sent byte (loopback)
  always begin
    @(posedge clk);
    if (spi_start && !m_stall) begin
      repeat (2) @(posedge clk);
      #1 spi_finish = 1'b0;
      repeat (4) @(posedge clk);
      #1 spi_rdata = spi_data;
      spi_finish = 1'b1;
    end
  end

  // monitor + scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_start) n_start++;
      if (done) n_done++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("rx_extra", exp_q.size(), 1);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks (entered and left at posedge+1)
  task automatic tx_push(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (tx_ready) ok = 1'b1;
    end
    if (!ok) check("tx_push_timeout", ok, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (ok) exp_q.push_back(d);
  endtask

  task automatic do_go(input logic [1:0] m, input logic [1:0] dv, input logic [7:0] len);
    go = 1'b1; cfg_mode = m; cfg_clkdiv = dv; burst_len = len;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    bit seen;
    d0 = n_done;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk); #1;
      if (n_done > d0) seen = 1'b1;
    end
    check(tag, seen, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    rst_n = 1'b0; go = 1'b0; cfg_mode = 2'd0; cfg_clkdiv = 2'd0; burst_len = 8'd0;
    tx_valid = 1'b0; tx_data = 8'd0; rx_ready = 1'b1;
    spi_finish = 1'b1; spi_rdata = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_data", spi_data, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic burst with go->start latency
    tx_push(8'hA5);
    tx_push(8'h3C);
    s0 = n_start;
    do_go(2'd2, 2'd3, 8'd2);
    check("t2_lat_start0", spi_start, 0);
    check("t2_busy", busy, 1);
    @(posedge clk); #1;
    check("t2_lat_start1", spi_start, 1);
    check("t2_spi_data", spi_data, 8'hA5);
    check("t2_spi_mode", spi_mode, 2'd2);
    check("t2_spi_clkdiv", spi_clkdiv, 2'd3);
    wait_done(200, "t2_done");
    check("t2_starts", n_start - s0, 2);
    check("t2_rx_left", exp_q.size(), 0);
    check("t2_busy_after", busy, 0);
    check("t2_done_after", done, 0);

    // TX underrun stall
    tx_push(8'h11);
    s0 = n_start;
    do_go(2'd0, 2'd1, 8'd3);
    repeat (30) @(posedge clk);
    #1;
    check("t3_stall_starts", n_start - s0, 1);
    check("t3_stall_busy", busy, 1);
    tx_push(8'h22);
    tx_push(8'h33);
    wait_done(200, "t3_done");
    check("t3_starts", n_start - s0, 3);
    check("t3_rx_left", exp_q.size(), 0);

    // RX full stall
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) tx_push(8'(8'h80 + i));
    check("t4_tx_full", tx_ready, 0);
    s0 = n_start;
    do_go(2'd1, 2'd2, 8'd10);
    tx_push(8'h88);
    tx_push(8'h89);
    repeat (150) @(posedge clk);
    #1;
    check("t4_stall_starts", n_start - s0, 9);
    check("t4_stall_busy", busy, 1);
    check("t4_rx_valid", rx_valid, 1);
    check("t4_rx_head", rx_data, 8'h80);
    rx_ready = 1'b1;
    wait_done(200, "t4_done");
    check("t4_starts", n_start - s0, 10);
    check("t4_rx_left", exp_q.size(), 0);

    // wrap, concurrent push/pop, ignored go
    for (int b = 0; b < 3; b++) begin
      tx_push(8'(8'h40 + b * 7));
      tx_push(8'(8'h41 + b * 7));
      s0 = n_start;
      do_go(2'd1, 2'd1, 8'd7);
      for (int i = 2; i < 7; i++) tx_push(8'(8'h40 + b * 7 + i));
      do_go(2'd3, 2'd0, 8'd5);
      check("t5_mode_hold", spi_mode, 2'd1);
      wait_done(300, "t5_done");
      check("t5_starts", n_start - s0, 7);
      check("t5_rx_left", exp_q.size(), 0);
    end
    s0 = n_start;
    do_go(2'd2, 2'd2, 8'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_len0_busy", busy, 0);
    check("t5_len0_starts", n_start - s0, 0);
    check("t5_len0_mode", spi_mode, 2'd1);

`ifdef SPI_BURST_TIMEOUT_EN
    m_stall = 1'b1;
    tx_push(8'h5A);
    exp_q.delete();
    do_go(2'd0, 2'd0, 8'd1);
    wait_done(70000, "t6_timeout_done");
    check("t6_err", err, 1);
    check("t6_rx_valid", rx_valid, 0);
    m_stall = 1'b0;
    tx_push(8'h6B);
    do_go(2'd0, 2'd0, 8'd1);
    check("t6_err_clear", err, 0);
    wait_done(200, "t6_done2");
`else
    check("err_tied", err, 0);
`endif

    // asynchronous reset mid-burst
    tx_push(8'hC1);
    tx_push(8'hC2);
    do_go(2'd3, 2'd3, 8'd2);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("r_busy", busy, 0);
    check("r_spi_start", spi_start, 0);
    check("r_spi_data", spi_data, 0);
    check("r_spi_mode", spi_mode, 0);
    check("r_spi_clkdiv", spi_clkdiv, 0);
    check("r_tx_ready", tx_ready, 1);
    check("r_rx_valid", rx_valid, 0);
    check("r_rx_data", rx_data, 0);
    check("r_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("r_after_busy", busy, 0);
    check("r_after_rx_valid", rx_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
